tetris_move_ctrl: RTL and testbench

TETRIS_MOVE_CTRL -- requirements
Module: tetris_move_ctrl

---
 rtl/tetris_move_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_tetris_move_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_ctrl.sv
// Tetris move controller: collision check of a requested move, next-block
// generator driven by an LFSR, and a level-dependent gravity tick.
package tetris_move_ctrl_pkg;
   typedef enum logic [2:0] {
      MOVE_DOWN   = 3'd0,
      MOVE_LEFT   = 3'd1,
      MOVE_RIGHT  = 3'd2,
      MOVE_ROTATE = 3'd3,
      MOVE_APPEAR = 3'd4
   } move_t;

   // data[rot][row][col]; col 0 is the leftmost cell of a 4-cell row
   typedef struct packed {
      logic [3:0][3:0][3:0] data;
      logic [1:0]           rotation;
      logic [4:0]           x;
      logic [4:0]           y;
      logic [2:0]           color;
   } block_info_t;
endpackage

module tetris_move_ctrl
   import tetris_move_ctrl_pkg::*;
#(
   parameter int FIELD_ROW_CNT = 20,
   parameter int FIELD_COL_CNT = 10,
   parameter int INIT_PERIOD   = 50_000_000,
   parameter int MIN_PERIOD    = 5_000_000
) (
   input  logic                                          clk_i,
   input  logic                                          rst_n_i,
   input  logic                                          check_run_i,
   input  move_t                                         req_move_i,
   input  block_info_t                                   block_i,
   input  logic [FIELD_ROW_CNT+1:0][FIELD_COL_CNT+1:0]   field_i,
   output logic                                          check_done_o,
   output logic                                          can_move_o,
   output logic signed [1:0]                             move_x_o,
   output logic signed [1:0]                             move_y_o,
   input  logic                                          next_block_en_i,
   output block_info_t                                   next_block_o,
   input  logic                                          sys_srst_i,
   input  logic                                          level_changed_i,
   output logic                                          sys_event_o
);

   localparam int          EXT_ROWS = FIELD_ROW_CNT + 2;
   localparam int          EXT_COLS = FIELD_COL_CNT + 2;
   localparam int          ROW_IW   = $clog2(EXT_ROWS);
   localparam int          COL_IW   = $clog2(EXT_COLS);
   localparam logic [31:0] INIT_P   = 32'(INIT_PERIOD);
   localparam logic [31:0] MIN_P    = 32'(MIN_PERIOD);
   localparam logic [4:0]  SPAWN_X  = 5'(FIELD_COL_CNT / 2 - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_CHECK = 1'b1} state_t;

   function automatic logic [3:0][3:0] rot_cw(input logic [3:0][3:0] s);
      logic [3:0][3:0] r;
      r = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            r[2'(i)][2'(j)] = s[2'(3 - j)][2'(i)];
         end
      end
      return r;
   endfunction

   function automatic logic [3:0][3:0] shape0(input logic [2:0] t);
      logic [3:0][3:0] s;
      case (t)
         3'd0:    s = {4'b0000, 4'b0000, 4'b1111, 4'b0000};
         3'd1:    s = {4'b0000, 4'b0110, 4'b0110, 4'b0000};
         3'd2:    s = {4'b0000, 4'b0010, 4'b0111, 4'b0000};
         3'd3:    s = {4'b0000, 4'b0011, 4'b0110, 4'b0000};
         3'd4:    s = {4'b0000, 4'b0110, 4'b0011, 4'b0000};
         3'd5:    s = {4'b0000, 4'b0100, 4'b0111, 4'b0000};
         3'd6:    s = {4'b0000, 4'b0001, 4'b0111, 4'b0000};
         default: s = 16'h0000;
      endcase
      return s;
   endfunction

   state_t                                      state_r, state_s;
   logic [1:0]                                  row_cnt_r, row_cnt_s;
   logic                                        acc_r, acc_s;
   logic                                        done_r, done_s;
   logic                                        can_r, can_s;
   logic signed [1:0]                           mx_r, mx_s, my_r, my_s;
   logic signed [1:0]                           dx_s, dy_s;
   logic [1:0]                                  rot_s;
   logic                                        load_s;
   logic                                        row_ok_s;
   logic [3:0][3:0]                             shape_r;
   logic [4:0]                                  x_r, y_r;
   logic [FIELD_ROW_CNT+1:0][FIELD_COL_CNT+1:0] field_r;
   logic [15:0]                                 lfsr_r, mod_s;
   logic [2:0]                                  type_s;
   block_info_t                                 nb_r, nb_s;
   logic [31:0]                                 cnt_r, cnt_s, period_r, period_s, shrunk_s;
   logic                                        event_r, event_s;
   logic                                        unused_s;

   assign unused_s = ^{block_i.color, mod_s[15:3]};

   // Decode displacement and target rotation of the requested move
   always_comb begin
      dx_s  = 2'sb00;
      dy_s  = 2'sb00;
      rot_s = block_i.rotation;
      case (req_move_i)
         MOVE_LEFT:   dx_s  = 2'sb11;
         MOVE_RIGHT:  dx_s  = 2'sb01;
         MOVE_DOWN:   dy_s  = 2'sb01;
         MOVE_ROTATE: rot_s = block_i.rotation + 2'd1;
         MOVE_APPEAR: rot_s = block_i.rotation;
         default:     rot_s = block_i.rotation;
      endcase
   end

   // Test the four cells of the current shape row against the sampled field
   always_comb begin
      row_ok_s = 1'b1;
      for (int j = 0; j < 4; j++) begin
         int tr;
         int tc;
         tr = int'(y_r) + int'(my_r) + int'(row_cnt_r);
         tc = int'(x_r) + int'(mx_r) + j;
         if (shape_r[row_cnt_r][2'(j)]) begin
            if (tr < 0 || tr >= EXT_ROWS || tc < 0 || tc >= EXT_COLS) begin
               row_ok_s = 1'b0;
            end else if (field_r[tr[ROW_IW-1:0]][tc[COL_IW-1:0]]) begin
               row_ok_s = 1'b0;
            end else begin
               row_ok_s = row_ok_s;
            end
         end else begin
            row_ok_s = row_ok_s;
         end
      end
   end

   // Check FSM next state; a new run always restarts from row 0
   always_comb begin
      state_s   = state_r;
      row_cnt_s = row_cnt_r;
      acc_s     = acc_r;
      done_s    = 1'b0;
      can_s     = can_r;
      mx_s      = mx_r;
      my_s      = my_r;
      load_s    = 1'b0;
      if (check_run_i) begin
         load_s    = 1'b1;
         state_s   = ST_CHECK;
         row_cnt_s = 2'd0;
         acc_s     = 1'b1;
         can_s     = 1'b0;
         mx_s      = dx_s;
         my_s      = dy_s;
      end else begin
         case (state_r)
            ST_IDLE:  state_s = ST_IDLE;
            ST_CHECK: begin
               acc_s = acc_r & row_ok_s;
               if (row_cnt_r == 2'd3) begin
                  done_s  = 1'b1;
                  can_s   = acc_r & row_ok_s;
                  state_s = ST_IDLE;
               end else begin
                  row_cnt_s = row_cnt_r + 2'd1;
               end
            end
            default:  state_s = ST_IDLE;
         endcase
      end
   end

   // Check FSM state, result registers and sampled inputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= ST_IDLE;
         row_cnt_r <= 2'd0;
         acc_r     <= 1'b0;
         done_r    <= 1'b0;
         can_r     <= 1'b0;
         mx_r      <= 2'sb00;
         my_r      <= 2'sb00;
         shape_r   <= 16'h0000;
         x_r       <= 5'd0;
         y_r       <= 5'd0;
         field_r   <= '0;
      end else begin
         state_r   <= state_s;
         row_cnt_r <= row_cnt_s;
         acc_r     <= acc_s;
         done_r    <= done_s;
         can_r     <= can_s;
         mx_r      <= mx_s;
         my_r      <= my_s;
         if (load_s) begin
            shape_r <= block_i.data[rot_s];
            x_r     <= block_i.x;
            y_r     <= block_i.y;
            field_r <= field_i;
         end
      end
   end

   // Candidate next block from the current LFSR value
   always_comb begin
      mod_s            = lfsr_r % 16'd7;
      type_s           = mod_s[2:0];
      nb_s             = '0;
      nb_s.data[0]     = shape0(type_s);
      nb_s.data[1]     = rot_cw(nb_s.data[0]);
      nb_s.data[2]     = rot_cw(nb_s.data[1]);
      nb_s.data[3]     = rot_cw(nb_s.data[2]);
      nb_s.rotation    = 2'd0;
      nb_s.x           = SPAWN_X;
      nb_s.y           = 5'd0;
      nb_s.color       = type_s + 3'd1;
   end

   // Free-running LFSR (taps 16,14,13,11) and next-block register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lfsr_r <= 16'hACE1;
         nb_r   <= '0;
      end else begin
         lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
         if (next_block_en_i) begin
            nb_r <= nb_s;
         end
      end
   end

   // Gravity counter; >= keeps the wrap safe when the period shrinks below the count
   always_comb begin
      cnt_s    = cnt_r;
      period_s = period_r;
      event_s  = 1'b0;
      shrunk_s = period_r - (period_r >> 3);
      if (sys_srst_i) begin
         cnt_s    = 32'd0;
         period_s = INIT_P;
      end else begin
         if (cnt_r >= period_r - 32'd1) begin
            cnt_s   = 32'd0;
            event_s = 1'b1;
         end else begin
            cnt_s = cnt_r + 32'd1;
         end
         if (level_changed_i) begin
            period_s = (shrunk_s > MIN_P) ? shrunk_s : MIN_P;
         end else begin
            period_s = period_r;
         end
      end
   end

   // Gravity registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_r    <= 32'd0;
         period_r <= INIT_P;
         event_r  <= 1'b0;
      end else begin
         cnt_r    <= cnt_s;
         period_r <= period_s;
         event_r  <= event_s;
      end
   end

   assign check_done_o = done_r;
   assign can_move_o   = can_r;
   assign move_x_o     = mx_r;
   assign move_y_o     = my_r;
   assign next_block_o = nb_r;
   assign sys_event_o  = event_r;

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Directed bench for tetris_move_ctrl: table-driven move checks plus
// sequences for restart, reset abort, next-block generation and gravity.
module tb_tetris_move_ctrl;
   import tetris_move_ctrl_pkg::*;

   localparam int ER = 22;
   localparam int EC = 12;

   typedef logic [ER-1:0][EC-1:0] field_t;

   typedef struct {
      move_t      mv;
      int         typ;
      logic [1:0] rot;
      int         x;
      int         y;
      int         fsel;
      int         can;
      int         dx;
      int         dy;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              check_run;
   move_t             req_move;
   block_info_t       block_in;
   field_t            field_in;
   logic              check_done;
   logic              can_move;
   logic signed [1:0] move_x;
   logic signed [1:0] move_y;
   logic              nb_en;
   block_info_t       next_block;
   logic              sys_srst;
   logic              level_changed;
   logic              sys_event;
   logic [15:0]       lfsr_m;

   int errors = 0;
   int checks = 0;

   tetris_move_ctrl #(.INIT_PERIOD(16), .MIN_PERIOD(14)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .check_run_i(check_run), .req_move_i(req_move),
      .block_i(block_in), .field_i(field_in), .check_done_o(check_done),
      .can_move_o(can_move), .move_x_o(move_x), .move_y_o(move_y),
      .next_block_en_i(nb_en), .next_block_o(next_block), .sys_srst_i(sys_srst),
      .level_changed_i(level_changed), .sys_event_o(sys_event)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, one step per clock
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0][3:0] base_shape(input int t);
      case (t)
         0: return {4'b0000, 4'b0000, 4'b1111, 4'b0000};  // I
         1: return {4'b0000, 4'b0110, 4'b0110, 4'b0000};  // O
         2: return {4'b0000, 4'b0010, 4'b0111, 4'b0000};  // T
         3: return {4'b0000, 4'b0011, 4'b0110, 4'b0000};  // S
         4: return {4'b0000, 4'b0110, 4'b0011, 4'b0000};  // Z
         5: return {4'b0000, 4'b0100, 4'b0111, 4'b0000};  // J
         6: return {4'b0000, 4'b0001, 4'b0111, 4'b0000};  // L
         default: return 16'h0000;
      endcase
   endfunction

   function automatic block_info_t mk_block(input int t, input logic [1:0] rot, input int x, input int y);
      block_info_t b;
      b = '0;
      b.data[0] = base_shape(t);
      for (int r = 1; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               b.data[2'(r)][2'(i)][2'(j)] = b.data[2'(r - 1)][2'(3 - j)][2'(i)];
            end
         end
      end
      b.rotation = rot;
      b.x        = 5'(x);
      b.y        = 5'(y);
      b.color    = 3'(t + 1);
      return b;
   endfunction

   function automatic field_t mk_field(input int sel);
      field_t f;
      for (int r = 0; r < ER; r++) begin
         for (int c = 0; c < EC; c++) begin
            f[5'(r)][4'(c)] = (c == 0 || c == EC - 1 || r == ER - 1);
         end
      end
      if (sel == 1) f[5'd4][4'd5] = 1'b1;
      return f;
   endfunction

   // Called #1 after a rising edge; inputs are scrambled after the run edge
   task automatic run_check(input vec_t v, input int idx);
      int early;
      block_in  = mk_block(v.typ, v.rot, v.x, v.y);
      field_in  = mk_field(v.fsel);
      req_move  = v.mv;
      check_run = 1'b1;
      @(posedge clk); #1;
      check_run = 1'b0;
      field_in  = '1;
      req_move  = MOVE_APPEAR;
      block_in  = mk_block(1, 2'd0, 1, 1);
      chk($sformatf("v%0d move_x", idx), int'(move_x), v.dx);
      chk($sformatf("v%0d move_y", idx), int'(move_y), v.dy);
      early = int'(check_done);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         early += int'(check_done);
      end
      chk($sformatf("v%0d early done", idx), early, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d done", idx), int'(check_done), 1);
      chk($sformatf("v%0d can_move", idx), int'(can_move), v.can);
      @(posedge clk); #1;
      chk($sformatf("v%0d done width", idx), int'(check_done), 0);
      chk($sformatf("v%0d can hold", idx), int'(can_move), v.can);
   endtask

   task automatic wait_event(input int start, output int n);
      n = start;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         n++;
         if (sys_event) return;
      end
      n = -1;
   endtask

   vec_t vecs[12];

   initial begin
      int n, first, pulses, exp_t;
      block_info_t exp_b, held;

      vecs[0]  = '{MOVE_DOWN,   2, 2'd0, 4, 1,  0, 1,  0, 1};
      vecs[1]  = '{MOVE_LEFT,   0, 2'd0, 1, 1,  0, 0, -1, 0};
      vecs[2]  = '{MOVE_DOWN,   1, 2'd0, 4, 18, 0, 0,  0, 1};
      vecs[3]  = '{MOVE_ROTATE, 0, 2'd0, 9, 1,  0, 0,  0, 0};
      vecs[4]  = '{MOVE_RIGHT,  0, 2'd0, 7, 1,  0, 0,  1, 0};
      vecs[5]  = '{MOVE_RIGHT,  0, 2'd0, 6, 1,  0, 1,  1, 0};
      vecs[6]  = '{MOVE_APPEAR, 2, 2'd0, 4, 0,  0, 1,  0, 0};
      vecs[7]  = '{MOVE_LEFT,   0, 2'd0, 0, 1,  0, 0, -1, 0};
      vecs[8]  = '{MOVE_ROTATE, 0, 2'd3, 1, 1,  0, 1,  0, 0};
      vecs[9]  = '{MOVE_DOWN,   2, 2'd0, 4, 1,  1, 0,  0, 1};
      vecs[10] = '{MOVE_DOWN,   1, 2'd0, 4, 17, 0, 1,  0, 1};
      vecs[11] = '{MOVE_ROTATE, 2, 2'd0, 4, 1,  0, 1,  0, 0};

      rst_n = 1'b0; check_run = 1'b0; req_move = MOVE_DOWN; block_in = '0;
      field_in = mk_field(0); nb_en = 1'b0; sys_srst = 1'b0; level_changed = 1'b0;
      #12;
      chk("rst done", int'(check_done), 0);
      chk("rst can", int'(can_move), 0);
      chk("rst move_x", int'(move_x), 0);
      chk("rst move_y", int'(move_y), 0);
      chk("rst next_block", int'(next_block == '0), 1);
      chk("rst event", int'(sys_event), 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 12; v++) run_check(vecs[v], v);

      // restart: second run two cycles into a colliding check
      block_in = mk_block(2, 2'd0, 4, 1); field_in = mk_field(1); req_move = MOVE_DOWN;
      check_run = 1'b1;
      @(posedge clk); #1;
      check_run = 1'b0;
      @(posedge clk); #1;
      field_in = mk_field(0);
      check_run = 1'b1;
      @(posedge clk); #1;
      check_run = 1'b0;
      first = 0; pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (check_done) begin
            if (first == 0) first = k;
            pulses++;
         end
         if (k == 4) chk("restart can", int'(can_move), 1);
      end
      chk("restart done edge", first, 4);
      chk("restart pulses", pulses, 1);

      // next block generation
      for (int p = 0; p < 6; p++) begin
         exp_t = int'(lfsr_m % 16'd7);
         exp_b = mk_block(exp_t, 2'd0, 4, 0);
         nb_en = 1'b1;
         @(posedge clk); #1;
         nb_en = 1'b0;
         chk($sformatf("nb%0d color", p), int'(next_block.color), exp_t + 1);
         chk($sformatf("nb%0d rot", p), int'(next_block.rotation), 0);
         chk($sformatf("nb%0d x", p), int'(next_block.x), 4);
         chk($sformatf("nb%0d y", p), int'(next_block.y), 0);
         chk($sformatf("nb%0d data", p), int'(next_block.data == exp_b.data), 1);
         repeat (p % 3 + 1) @(posedge clk);
         #1;
      end
      held = next_block;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("nb hold", int'(next_block == held), 1);
      end

      // reset in the middle of a check
      block_in = mk_block(2, 2'd0, 4, 1); field_in = mk_field(0); req_move = MOVE_DOWN;
      check_run = 1'b1;
      @(posedge clk); #1;
      check_run = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst done", int'(check_done), 0);
      chk("midrst move_y", int'(move_y), 0);
      chk("midrst next_block", int'(next_block == '0), 1);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         pulses += int'(check_done);
      end
      chk("midrst no done", pulses, 0);
      chk("midrst can", int'(can_move), 0);
      chk("midrst move_x", int'(move_x), 0);

      // gravity period, level speed-up, floor and restart priority
      sys_srst = 1'b1;
      @(posedge clk); #1;
      sys_srst = 1'b0;
      chk("srst no event", int'(sys_event), 0);
      wait_event(0, n); chk("grav first", n, 16);
      wait_event(0, n); chk("grav second", n, 16);
      level_changed = 1'b1;
      @(posedge clk); #1;
      level_changed = 1'b0;
      wait_event(1, n); chk("level1 first", n, 14);
      wait_event(0, n); chk("level1 second", n, 14);
      level_changed = 1'b1;
      @(posedge clk); #1;
      level_changed = 1'b0;
      wait_event(1, n); chk("level2 floor", n, 14);
      wait_event(0, n); chk("level2 floor again", n, 14);
      sys_srst = 1'b1; level_changed = 1'b1;
      @(posedge clk); #1;
      sys_srst = 1'b0; level_changed = 1'b0;
      chk("srst prio no event", int'(sys_event), 0);
      wait_event(0, n); chk("srst prio period", n, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
